// File: rtl/exe_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// exe_hazard_fwd_ctrl
//
// Execute-stage sequencer for a 5-stage ARM-style pipeline. It shadows the
// two instructions ahead of decode (the EXE slot and the MEM slot). It
// detects RAW hazards against them, drives the decode stall, handles
// taken-branch flush, and registers the Rn/Rm forwarding selects so they
// line up with the instruction that occupies EXE.
//
// Ports
//   clk            pipeline clock, rising edge
//   rst            asynchronous active-low reset
//   fwd_enable     1 = forward from MEM/WB; 0 = stall on every RAW hazard
//   id_valid       decode holds a real instruction
//   id_src1/2      Rn / Rm indices of the decode instruction
//   id_src1/2_used decode instruction reads Rn / Rm
//   id_dest        decode destination index
//   id_wb_en       decode instruction writes id_dest
//   id_mem_read    decode instruction is a load
//   branch_taken   EXE resolves a taken branch this cycle
//   stall          combinational: freeze PC and IF/ID, insert a bubble
//   exe_valid      registered: EXE slot holds a real instruction
//   val_rn_sel     registered: 00 regfile, 01 one ahead (MEM), 10 two ahead (WB)
//   val_rm_sel     registered: same encoding as val_rn_sel
//   stall_count    saturating count of stall cycles
//
// Flow control: decode presents an instruction with id_valid=1. The
// instruction is accepted into EXE on a rising edge only when stall=0 and
// branch_taken=0. While stall=1 decode must hold the same instruction
// stable, and a bubble (valid=0) enters EXE instead. A taken branch
// discards the decode instruction, and the front end refetches it.
// ---------------------------------------------------------------------------
module exe_hazard_fwd_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_enable,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  output logic             stall,
  output logic             exe_valid,
  output logic [1:0]       val_rn_sel,
  output logic [1:0]       val_rm_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0]       SEL_RF  = 2'b00;
  localparam logic [1:0]       SEL_MEM = 2'b01;
  localparam logic [1:0]       SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // EXE slot: the instruction one ahead of decode
  logic             exe_v;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb;
  logic             exe_mr;
  // MEM slot: the instruction two ahead of decode
  logic             mem_v;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb;

  // Source/slot matches, evaluated against the slots before the edge
  logic s1_exe, s2_exe, s1_mem, s2_mem;
  logic hazard;
  logic load_id;
  logic [1:0] rn_sel_d, rm_sel_d;

  assign s1_exe = id_src1_used & exe_v & exe_wb & (id_src1 == exe_dest);
  assign s2_exe = id_src2_used & exe_v & exe_wb & (id_src2 == exe_dest);
  assign s1_mem = id_src1_used & mem_v & mem_wb & (id_src1 == mem_dest);
  assign s2_mem = id_src2_used & mem_v & mem_wb & (id_src2 == mem_dest);

  // With forwarding, only a load directly ahead cannot be bypassed, because
  // its data appears one cycle too late. Without forwarding, any producer
  // still in EXE or MEM must drain. The register file is write-before-read,
  // so a producer in WB is already visible.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (fwd_enable) hazard = (s1_exe | s2_exe) & exe_mr;
      else            hazard = s1_exe | s2_exe | s1_mem | s2_mem;
    end
  end

  // A flush overrides a stall: the decode instruction is being discarded.
  assign stall   = hazard & ~branch_taken;
  assign load_id = id_valid & ~stall & ~branch_taken;

  // The EXE match is tested first, so the newest producer wins.
  always_comb begin
    rn_sel_d = SEL_RF;
    rm_sel_d = SEL_RF;
    if (load_id && fwd_enable) begin
      if (s1_exe)      rn_sel_d = SEL_MEM;
      else if (s1_mem) rn_sel_d = SEL_WB;
      if (s2_exe)      rm_sel_d = SEL_MEM;
      else if (s2_mem) rm_sel_d = SEL_WB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_v       <= 1'b0;
      exe_dest    <= '0;
      exe_wb      <= 1'b0;
      exe_mr      <= 1'b0;
      mem_v       <= 1'b0;
      mem_dest    <= '0;
      mem_wb      <= 1'b0;
      val_rn_sel  <= SEL_RF;
      val_rm_sel  <= SEL_RF;
      stall_count <= '0;
    end else begin
      mem_v      <= exe_v;
      mem_dest   <= exe_dest;
      mem_wb     <= exe_wb;
      exe_v      <= load_id;
      exe_dest   <= id_dest;
      exe_wb     <= id_wb_en & load_id;
      exe_mr     <= id_mem_read & load_id;
      val_rn_sel <= rn_sel_d;
      val_rm_sel <= rm_sel_d;
      if (stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
    end
  end

  assign exe_valid = exe_v;

endmodule

// File: tb/tb_exe_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exe_hazard_fwd_ctrl
//
// Directed testbench for exe_hazard_fwd_ctrl. It uses a narrow stall counter
// so that the counter can saturate within a short run. Each step drives the
// decode inputs just after a rising edge. The combinational stall is checked
// before the next edge. The registered outputs are checked 1 ns after the
// edge.
// ---------------------------------------------------------------------------
module tb_exe_hazard_fwd_ctrl;

  localparam int REG_W    = 4;
  localparam int TB_CNT_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             fwd_enable;
  logic             id_valid;
  logic [REG_W-1:0] id_src1, id_src2, id_dest;
  logic             id_src1_used, id_src2_used;
  logic             id_wb_en, id_mem_read;
  logic             branch_taken;
  logic             stall;
  logic             exe_valid;
  logic [1:0]       val_rn_sel, val_rm_sel;
  logic [TB_CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  exe_hazard_fwd_ctrl #(.REG_W(REG_W), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_enable   (fwd_enable),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .branch_taken (branch_taken),
    .stall        (stall),
    .exe_valid    (exe_valid),
    .val_rn_sel   (val_rn_sel),
    .val_rm_sel   (val_rm_sel),
    .stall_count  (stall_count)
  );

  // driver tasks
  task automatic drive(input logic v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, input logic [3:0] d,
                       input logic wb, input logic mr);
    id_valid     = v;
    id_src1      = s1;
    id_src1_used = u1;
    id_src2      = s2;
    id_src2_used = u2;
    id_dest      = d;
    id_wb_en     = wb;
    id_mem_read  = mr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush2();
    idle();
    tick();
    tick();
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    fwd_enable   = 1'b1;
    branch_taken = 1'b0;
    idle();
    // reset values
    #2;
    chk("rst_exe_valid", 32'(exe_valid), 32'd0);
    chk("rst_rn_sel", 32'(val_rn_sel), 32'd0);
    chk("rst_rm_sel", 32'(val_rm_sel), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ADD R1,R2,R3 ; SUB R2,R1,R3 back to back
    drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    chk("t1_add_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
    chk("t1_sub_stall", 32'(stall), 32'd0);
    tick();
    chk("t1_exe_valid", 32'(exe_valid), 32'd1);
    chk("t1_rn_sel", 32'(val_rn_sel), 32'd1);
    chk("t1_rm_sel", 32'(val_rm_sel), 32'd0);
    flush2();
    chk("flush_exe_valid", 32'(exe_valid), 32'd0);

    // ADD R1 ; non-writing NOP ; ORR R4,R5,R1
    drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);
    chk("t2_stall", 32'(stall), 32'd0);
    tick();
    chk("t2_exe_valid", 32'(exe_valid), 32'd1);
    chk("t2_rn_sel", 32'(val_rn_sel), 32'd0);
    chk("t2_rm_sel", 32'(val_rm_sel), 32'd2);
    flush2();

    // MOV R1,R2 ; ADD R1,R2,R3 ; CMP R1,R1 -> newest producer wins
    drive(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("t3_stall", 32'(stall), 32'd0);
    tick();
    chk("t3_rn_sel", 32'(val_rn_sel), 32'd1);
    chk("t3_rm_sel", 32'(val_rm_sel), 32'd1);
    chk("t3_count", 32'(stall_count), 32'd0);
    flush2();

    // LDR R4,[R0] ; ADD R5,R4,R4 -> one load-use stall, then select WB
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    chk("t4_stall_1", 32'(stall), 32'd1);
    tick();
    chk("t4_bubble", 32'(exe_valid), 32'd0);
    chk("t4_count_1", 32'(stall_count), 32'd1);
    chk("t4_stall_2", 32'(stall), 32'd0);
    tick();
    chk("t4_exe_valid", 32'(exe_valid), 32'd1);
    chk("t4_rn_sel", 32'(val_rn_sel), 32'd2);
    chk("t4_rm_sel", 32'(val_rm_sel), 32'd2);
    chk("t4_count_2", 32'(stall_count), 32'd1);
    flush2();

    // load-use hazard with a taken branch in the same cycle -> flush wins
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
    tick();
    branch_taken = 1'b1;
    drive(1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    chk("t5_stall", 32'(stall), 32'd0);
    tick();
    branch_taken = 1'b0;
    chk("t5_exe_valid", 32'(exe_valid), 32'd0);
    chk("t5_count", 32'(stall_count), 32'd1);
    flush2();

    // forwarding off: ADD R1 ; SUB R2,R1,R1 -> two stalls, selects 00
    fwd_enable = 1'b0;
    drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
    chk("t6_stall_1", 32'(stall), 32'd1);
    tick();
    chk("t6_bubble", 32'(exe_valid), 32'd0);
    chk("t6_stall_2", 32'(stall), 32'd1);
    tick();
    chk("t6_stall_3", 32'(stall), 32'd0);
    tick();
    chk("t6_exe_valid", 32'(exe_valid), 32'd1);
    chk("t6_rn_sel", 32'(val_rn_sel), 32'd0);
    chk("t6_rm_sel", 32'(val_rm_sel), 32'd0);
    chk("t6_count", 32'(stall_count), 32'd3);

    // seven more two-stall pairs: 3 + 14 = 17 stalls saturate at 15
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
      tick();
      tick();
      tick();
    end
    chk("t7_count_sat", 32'(stall_count), 32'd15);
    fwd_enable = 1'b1;
    flush2();

    // async reset in the middle of a load-use stall
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    chk("t8_stall_pre", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("t8_exe_valid", 32'(exe_valid), 32'd0);
    chk("t8_rn_sel", 32'(val_rn_sel), 32'd0);
    chk("t8_rm_sel", 32'(val_rm_sel), 32'd0);
    chk("t8_count", 32'(stall_count), 32'd0);
    chk("t8_stall", 32'(stall), 32'd0);
    idle();
    tick();
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_hazard_fwd_ctrl.md
Name: exe_hazard_fwd_ctrl

Overview:
- Sequences the execute stage of the ARM-style 5-stage pipeline.
- Tracks destination registers of the two instructions ahead of decode (now in EXE and MEM), and produces registered Rn/Rm forwarding selects aligned to the instruction entering EXE.
- Detects load-use and no-forward hazards, drives decode stall and handles branch flush.
- Sits between ID/EXE pipeline register and EXE stage; keeps a saturating stall-cycle counter.

Parameters:
REG_W, 4, register index width
CNT_W, 16, stall counter width

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous active-low reset
fwd_enable  input  1  1 = forwarding on; 0 = resolve every RAW hazard by stalling
id_valid  input  1  decode holds a real instruction
id_src1  input  REG_W  Rn index of decode instruction
id_src2  input  REG_W  Rm index of decode instruction
id_src1_used  input  1  instruction reads Rn
id_src2_used  input  1  instruction reads Rm (register operand or store data)
id_dest  input  REG_W  destination index
id_wb_en  input  1  instruction writes id_dest
id_mem_read  input  1  instruction is a load
branch_taken  input  1  EXE resolves a taken branch this cycle
stall  output  1  combinational; freeze PC and IF/ID, insert bubble
exe_valid  output  1  registered; EXE slot holds a real instruction
val_rn_sel  output  2  registered; 00 regfile, 01 result one ahead (MEM), 10 result two ahead (WB)
val_rm_sel  output  2  registered; encoding as val_rn_sel
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- State: EXE slot {valid, dest, wb_en, mem_read}; MEM slot {valid, dest, wb_en}.
- Match: srcN matches slot S when srcN_used & S.valid & S.wb_en & srcN == S.dest. Register file is write-before-read; producers three or more ahead need no action.
- Hazard (only when id_valid):
  - fwd_enable=1: stall if any used source matches EXE slot and EXE.mem_read=1 (load-use).
  - fwd_enable=0: stall if any used source matches EXE slot or MEM slot.
- stall = hazard & ~branch_taken.
- Each rising edge:
  - MEM slot <= EXE slot (always).
  - EXE slot <= bubble (valid=0) if stall, branch_taken, or ~id_valid; otherwise the decode instruction.
  - Selects loaded in the same edge as the EXE slot, computed against pre-edge slots.
  - Per source with fwd_enable=1: 01 if matches EXE slot; else 10 if matches MEM slot; else 00. EXE slot has priority, so the newest producer wins.
  - fwd_enable=0, bubble, or unused source: select 00.
  - exe_valid = new EXE slot valid.
- Latency: selects valid during the cycle the instruction occupies EXE, i.e. one cycle after its decode cycle. Load-use costs exactly 1 stall cycle, then select 10. No-forward mode costs 2 stall cycles (distance 1) or 1 (distance 2).
- branch_taken with a hazard: flush wins, stall=0, counter unchanged, bubble enters EXE.
- stall_count increments by 1 each cycle stall=1, saturates at all-ones, no wrap.
- Reset (async, any time including mid-stall): both slots invalid, exe_valid=0, selects 00, stall_count=0, stall=0 while rst low.
- fwd_enable may change on any edge; it takes effect on the next hazard evaluation.

Test Plan:
- ADD R1 then SUB R2,R1,R3 back-to-back, fwd on -> SUB's EXE cycle val_rn_sel=01, val_rm_sel=00, no stall.
- ADD R1; NOP-equivalent (wb_en=0); ORR R4,R5,R1 -> ORR EXE cycle val_rm_sel=10.
- MOV R1 then ADD R1 then CMP R1,R1 -> both selects 01 (newest wins), stall_count stays 0.
- LDR R4 then ADD R5,R4,R4 -> stall=1 for one cycle, exe_valid=0 next, then ADD in EXE with both selects 10, stall_count=1.
- fwd_enable=0, ADD R1 then SUB R2,R1,R1 -> stall 2 cycles, selects 00, stall_count=2; set counter near all-ones with repeated hazards -> stays saturated.
- LDR R4 / ADD uses R4 with branch_taken=1 same cycle -> stall=0, exe_valid=0 next, count unchanged; assert rst=0 mid-stall -> exe_valid=0, selects 00, stall_count=0 immediately.
